// File: rtl/sdm_mash111.sv
// MASH 1-1-1 sigma-delta modulator for a fractional-N divider: turns the shadowed
// fractional word into a per-reference-cycle MMD modulus with optional LFSR dither.
module sdm_mash111 #(
   parameter int W  = 15,
   parameter int NW = 8
) (
   input  logic          clk_ref,
   input  logic          rstn,
   input  logic          enable,
   input  logic          load,
   input  logic [W-1:0]  frac_in,
   input  logic [NW-1:0] nint_in,
   input  logic [1:0]    order,
   input  logic          dither_en,
   output logic [NW:0]   div_out,
   output logic          sdm_qn,
   output logic [W-1:0]  frac_out,
   output logic          valid
);

   localparam logic [1:0] ORD_INT  = 2'd0;
   localparam logic [1:0] ORD_M1   = 2'd1;
   localparam logic [1:0] ORD_M11  = 2'd2;
   localparam logic [1:0] ORD_M111 = 2'd3;

   localparam int                LFSR_W    = 15;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

   // Shadow registers
   logic [W-1:0]  frac_q;
   logic [NW-1:0] nint_q;
   logic [1:0]    order_q;
   logic          dither_q;

   // Modulator state
   logic [W-1:0]      acc1_q, acc2_q, acc3_q;
   logic              c1_q, c2_q, c3_q;
   logic              c2d_q, c3d_q, c3dd_q;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic              primed_q;

   // Output registers
   logic [NW:0] div_q, div_d;
   logic        qn_q;
   logic        valid_q;

   logic [W:0]           stage1_d, stage2_d, stage3_d;
   logic signed [3:0]    y1, y2, y3, y;
   logic signed [NW+1:0] div_sum;

   always_comb begin
      // Each stage adds the value the previous stage stores on this same edge.
      stage1_d = {1'b0, acc1_q} + {1'b0, frac_q} + {{W{1'b0}}, dither_q & lfsr_q[0]};
      stage2_d = {1'b0, acc2_q} + {1'b0, stage1_d[W-1:0]};
      stage3_d = {1'b0, acc3_q} + {1'b0, stage2_d[W-1:0]};

      y1 = {3'b000, c1_q};
      y2 = y1 + {3'b000, c2_q} - {3'b000, c2d_q};
      y3 = y2 + {3'b000, c3_q} - {2'b00, c3d_q, 1'b0} + {3'b000, c3dd_q};

      // NOTE: default assignment first so no path through this block infers a latch.
      y = '0;
      case (order_q)
         ORD_M1:   y = y1;
         ORD_M11:  y = y2;
         ORD_M111: y = y3;
         default:  y = '0;
      endcase

      // A negative modulus is not realisable by the MMD, so it is clamped to zero.
      div_sum = $signed({2'b00, nint_q}) + $signed({{(NW-2){y[3]}}, y});
      div_d   = div_sum[NW+1] ? '0 : div_sum[NW:0];

      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[14] ^ lfsr_q[13]};
   end

   always_ff @(posedge clk_ref or negedge rstn) begin
      if (!rstn) begin
         frac_q   <= '0;
         nint_q   <= '0;
         order_q  <= ORD_INT;
         dither_q <= 1'b0;
         acc1_q   <= '0;
         acc2_q   <= '0;
         acc3_q   <= '0;
         c1_q     <= 1'b0;
         c2_q     <= 1'b0;
         c3_q     <= 1'b0;
         c2d_q    <= 1'b0;
         c3d_q    <= 1'b0;
         c3dd_q   <= 1'b0;
         lfsr_q   <= LFSR_SEED;
         primed_q <= 1'b0;
         div_q    <= '0;
         qn_q     <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         if (enable) begin
            acc1_q   <= stage1_d[W-1:0];
            c1_q     <= stage1_d[W];
            acc2_q   <= stage2_d[W-1:0];
            c2_q     <= stage2_d[W];
            acc3_q   <= stage3_d[W-1:0];
            c3_q     <= stage3_d[W];
            c2d_q    <= c2_q;
            c3d_q    <= c3_q;
            c3dd_q   <= c3d_q;
            lfsr_q   <= lfsr_d;
            primed_q <= 1'b1;
            div_q    <= div_d;
            qn_q     <= (order_q != ORD_INT) && c1_q;
            valid_q  <= (order_q != ORD_INT) && primed_q;
         end else begin
            div_q   <= {1'b0, nint_q};
            qn_q    <= 1'b0;
            valid_q <= 1'b0;
         end

         if (load) begin
            frac_q   <= frac_in;
            nint_q   <= nint_in;
            order_q  <= order;
            dither_q <= dither_en;
            // NOTE: these later non-blocking writes override the stage update above,
            // so an order change wins over the same-edge accumulation.
            if (order != order_q) begin
               acc2_q <= '0;
               acc3_q <= '0;
               c2_q   <= 1'b0;
               c3_q   <= 1'b0;
               c2d_q  <= 1'b0;
               c3d_q  <= 1'b0;
               c3dd_q <= 1'b0;
            end
         end
      end
   end

   assign div_out  = div_q;
   assign sdm_qn   = qn_q;
   assign frac_out = frac_q;
   assign valid    = valid_q;

endmodule
